// File: rtl/spi_prog_loader.sv
// SPI-slave program loader: receives a framed image over SPI and
// replays it onto the core's instruction-memory load port.
module spi_prog_loader #(
  parameter int          MEM_DEPTH = 19,
  parameter int          ADDR_W    = 5,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [7:0]        prog_data,
  output logic              core_hold,
  output logic              core_start,
  output logic              done,
  output logic [1:0]        err
);

  localparam logic [7:0] MAX_LEN = 8'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, CSUM, DONE, ERR
  } state_t;

  state_t state, state_nxt, byte_nxt;

  logic [2:0]        sclk_q, cs_q;
  logic [1:0]        mosi_q;
  logic              sclk_rise, cs_rise, cs_fall;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              byte_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        rem, sum;
  logic              len_bad;
  logic              hdr_hit, len_ok, len_err, wr;
  logic              sum_ok, sum_err, abort;

  // index 1 is the synchronised level, index 2 its previous sample
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign len_bad   = (shreg == 8'd0) | (shreg > MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_q[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg      <= {shreg[6:0], mosi_q[1]};
        bit_cnt    <= bit_cnt + 3'd1;
        byte_valid <= (bit_cnt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // byte is consumed first; an abort then applies to the resulting state
  always_comb begin
    byte_nxt = state;
    if (byte_valid) begin
      unique case (state)
        IDLE:    if (shreg == HDR_BYTE) byte_nxt = LEN;
        LEN:     byte_nxt = len_bad ? ERR : DATA;
        DATA:    if (rem == 8'd1) byte_nxt = CSUM;
        CSUM:    byte_nxt = (shreg == sum) ? DONE : ERR;
        default: byte_nxt = state;
      endcase
    end
    state_nxt = byte_nxt;
    if (cs_fall && (state == DONE || state == ERR))
      state_nxt = IDLE;
    if (abort)
      state_nxt = ERR;
  end

  always_comb begin
    hdr_hit = 1'b0;
    len_ok  = 1'b0;
    len_err = 1'b0;
    wr      = 1'b0;
    sum_ok  = 1'b0;
    sum_err = 1'b0;
    if (byte_valid) begin
      unique case (1'b1)
        state == IDLE: hdr_hit = (shreg == HDR_BYTE);
        state == LEN:  begin len_ok = ~len_bad; len_err = len_bad; end
        state == DATA: wr = 1'b1;
        state == CSUM: begin
          sum_ok  = (shreg == sum);
          sum_err = (shreg != sum);
        end
        default: ;
      endcase
    end
    abort = cs_rise &
      (byte_nxt == LEN || byte_nxt == DATA || byte_nxt == CSUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      core_hold  <= 1'b0;
      core_start <= 1'b0;
      done       <= 1'b0;
      err        <= 2'b00;
      addr_q     <= '0;
      rem        <= '0;
      sum        <= '0;
    end else begin
      prog_we    <= wr;
      core_start <= sum_ok;
      if (hdr_hit) begin
        core_hold <= 1'b1;
        done      <= 1'b0;
        err       <= 2'b00;
        sum       <= '0;
      end
      if (len_ok) begin
        rem    <= shreg;
        addr_q <= '0;
      end
      if (wr) begin
        prog_data <= shreg;
        prog_addr <= addr_q;
        addr_q    <= addr_q + ADDR_W'(1);
        sum       <= sum + shreg;
        rem       <= rem - 8'd1;
      end
      if (sum_ok) begin
        done      <= 1'b1;
        core_hold <= 1'b0;
      end
      if (len_err) err <= 2'b01;
      if (sum_err) err <= 2'b10;
      if (abort)   err <= 2'b11;
    end
  end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Bench for spi_prog_loader: directed frame table, reset-mid-frame
// sequence and random frames against a frame-level parser model.
module tb_spi_prog_loader;

  localparam int DEPTH = 19;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic       core_hold;
  logic       core_start;
  logic       done;
  logic [1:0] err;

  spi_prog_loader dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .core_hold(core_hold), .core_start(core_start),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_rise = 0;
  int starts = 0;
  logic [12:0] wq[$];

  int m_done = 0, m_err = 0, m_hold = 0, m_starts = 0;
  logic [12:0] mq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // observe the load port; every pulse must come 4 clk after the last sclk rise
  always @(negedge clk) begin
    if (rst_n) begin
      if (prog_we) begin
        wq.push_back({prog_addr, prog_data});
        check("we_latency", cyc - last_rise, 4);
      end
      if (core_start) begin
        starts++;
        check("start_latency", cyc - last_rise, 4);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    tick(4);
    sclk = 1'b1;
    last_rise = cyc;
    tick(4);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic run_frame(input logic [7:0] q[$], input int bits);
    wq.delete();
    starts = 0;
    cs_n = 1'b0;
    tick(4);
    foreach (q[i]) send_byte(q[i]);
    for (int i = 0; i < bits; i++) send_bit(1'($urandom_range(0, 1)));
    tick(4);
    cs_n = 1'b1;
    tick(10);
  endtask

  // frame parser: header search, length, payload, checksum; frame end aborts
  task automatic model_frame(input logic [7:0] b[$]);
    int i, n, len;
    logic [7:0] s;
    mq.delete();
    m_starts = 0;
    n = b.size();
    i = 0;
    while (i < n && b[i] != 8'hA5) i++;
    if (i >= n) return;
    m_hold = 1; m_done = 0; m_err = 0;
    if (i + 1 >= n) begin m_err = 3; return; end
    len = int'(b[i+1]);
    if (len == 0 || len > DEPTH) begin m_err = 1; return; end
    s = 8'h00;
    for (int k = 0; k < len; k++) begin
      if (i + 2 + k >= n) begin m_err = 3; return; end
      mq.push_back({5'(k), b[i+2+k]});
      s = s + b[i+2+k];
    end
    if (i + 2 + len >= n) begin m_err = 3; return; end
    if (b[i+2+len] == s) begin
      m_done = 1; m_hold = 0; m_starts = 1;
    end else begin
      m_err = 2;
    end
  endtask

  task automatic compare_model(input string tag);
    int n;
    check({tag, "_done"}, int'(done), m_done);
    check({tag, "_err"}, int'(err), m_err);
    check({tag, "_hold"}, int'(core_hold), m_hold);
    check({tag, "_starts"}, starts, m_starts);
    check({tag, "_nwr"}, wq.size(), mq.size());
    n = (wq.size() < mq.size()) ? wq.size() : mq.size();
    for (int k = 0; k < n; k++) check({tag, "_wr"}, int'(wq[k]), int'(mq[k]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, int'(prog_we), 0);
    check({tag, "_addr"}, int'(prog_addr), 0);
    check({tag, "_data"}, int'(prog_data), 0);
    check({tag, "_hold"}, int'(core_hold), 0);
    check({tag, "_start"}, int'(core_start), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  typedef struct packed {
    logic [3:0]      n;
    logic [0:7][7:0] b;
    logic [2:0]      bits;
    logic [3:0]      nwr;
    logic [0:3][7:0] wd;
    logic            dn;
    logic [1:0]      er;
    logic            hd;
    logic [1:0]      st;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] fq[$];
    logic [7:0] s, g;
    int kind, len, bits, cut;

    tbl[0] = '{4'd6, 64'hA5_03_01_2A_0A_35_00_00, 3'd0, 4'd3, 32'h01_2A_0A_00, 1'b1, 2'd0, 1'b0, 2'd1};
    tbl[1] = '{4'd5, 64'hA5_02_01_05_00_00_00_00, 3'd0, 4'd2, 32'h01_05_00_00, 1'b0, 2'd2, 1'b1, 2'd0};
    tbl[2] = '{4'd2, 64'hA5_00_00_00_00_00_00_00, 3'd0, 4'd0, 32'h0, 1'b0, 2'd1, 1'b1, 2'd0};
    tbl[3] = '{4'd2, 64'hA5_14_00_00_00_00_00_00, 3'd0, 4'd0, 32'h0, 1'b0, 2'd1, 1'b1, 2'd0};
    tbl[4] = '{4'd5, 64'h3C_A5_01_07_07_00_00_00, 3'd0, 4'd1, 32'h07_00_00_00, 1'b1, 2'd0, 1'b0, 2'd1};
    tbl[5] = '{4'd3, 64'hA5_02_11_00_00_00_00_00, 3'd4, 4'd1, 32'h11_00_00_00, 1'b0, 2'd3, 1'b1, 2'd0};
    tbl[6] = '{4'd4, 64'hA5_01_0A_0A_00_00_00_00, 3'd0, 4'd1, 32'h0A_00_00_00, 1'b1, 2'd0, 1'b0, 2'd1};
    tbl[7] = '{4'd2, 64'h3C_5A_00_00_00_00_00_00, 3'd0, 4'd0, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0};
    tbl[8] = '{4'd6, 64'hA5_01_07_07_A5_02_00_00, 3'd0, 4'd1, 32'h07_00_00_00, 1'b1, 2'd0, 1'b0, 2'd1};
    tbl[9] = '{4'd1, 64'hA5_00_00_00_00_00_00_00, 3'd0, 4'd0, 32'h0, 1'b0, 2'd3, 1'b1, 2'd0};

    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(3);

    for (int r = 0; r < 10; r++) begin
      fq.delete();
      for (int k = 0; k < int'(tbl[r].n); k++) fq.push_back(tbl[r].b[k]);
      model_frame(fq);
      run_frame(fq, int'(tbl[r].bits));
      check($sformatf("row%0d_nwr", r), wq.size(), int'(tbl[r].nwr));
      for (int k = 0; k < wq.size() && k < int'(tbl[r].nwr); k++)
        check($sformatf("row%0d_wr%0d", r, k), int'(wq[k]),
              int'({5'(k), tbl[r].wd[k]}));
      check($sformatf("row%0d_done", r), int'(done), int'(tbl[r].dn));
      check($sformatf("row%0d_err", r), int'(err), int'(tbl[r].er));
      check($sformatf("row%0d_hold", r), int'(core_hold), int'(tbl[r].hd));
      check($sformatf("row%0d_starts", r), starts, int'(tbl[r].st));
    end

    // reset while mid-way through the payload
    wq.delete();
    cs_n = 1'b0;
    tick(4);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(2);
    check("prerst_nwr", wq.size(), 2);
    check("prerst_hold", int'(core_hold), 1);
    check("prerst_addr", int'(prog_addr), 1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    tick(2);
    rst_n = 1'b1;
    cs_n = 1'b1;
    tick(10);
    m_done = 0; m_err = 0; m_hold = 0;
    fq = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h77};
    model_frame(fq);
    run_frame(fq, 0);
    compare_model("postrst");
    check("postrst_done", int'(done), 1);

    for (int t = 0; t < 24; t++) begin
      fq.delete();
      kind = (t == 0) ? 0 : $urandom_range(0, 4);
      bits = 0;
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h3C;
        fq.push_back(g);
      end
      fq.push_back(8'hA5);
      if (kind == 3) begin
        fq.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(20, 255)));
      end else begin
        len = (t == 0) ? DEPTH : $urandom_range(1, DEPTH);
        fq.push_back(8'(len));
        s = 8'h00;
        for (int k = 0; k < len; k++) begin
          g = 8'($urandom_range(0, 255));
          fq.push_back(g);
          s = s + g;
        end
        if (kind == 2) s = s ^ 8'($urandom_range(1, 255));
        fq.push_back(s);
      end
      if (kind == 4) begin
        cut = $urandom_range(1, fq.size() - 1);
        while (fq.size() > cut) void'(fq.pop_back());
        bits = $urandom_range(1, 7);
      end
      model_frame(fq);
      run_frame(fq, bits);
      compare_model($sformatf("rnd%0d_k%0d", t, kind));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
